// File: rtl/dmux_four_way_pkg.sv
// Shared select encoding for the four-way demultiplexer.
package dmux_four_way_pkg;
  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'd0;
  localparam sel_t SEL_B = 2'd1;
  localparam sel_t SEL_C = 2'd2;
  localparam sel_t SEL_D = 2'd3;
endpackage

// File: rtl/dmux_1to2.sv
// Combinational 1-to-2 demultiplexer: sel=0 routes to a, sel=1 routes to b.
module dmux_1to2 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] in,
  input  logic             sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b
);
  assign a = sel ? '0 : in;
  assign b = sel ? in : '0;
endmodule

// File: rtl/dmux_four_way.sv
// Registered 1-to-4 demultiplexer built from a tree of dmux_1to2 instances.
// Build option DMUX_FOUR_WAY_HOLD_EN: en=0 holds outputs instead of clearing them.
module dmux_four_way
  import dmux_four_way_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d
);
  sel_t             sel_p0;
  logic [WIDTH-1:0] lo_p0, hi_p0;
  logic [WIDTH-1:0] a_p0, b_p0, c_p0, d_p0;
  logic [WIDTH-1:0] a_p1, b_p1, c_p1, d_p1;

  assign sel_p0 = sel;

  // Stage p0: decode tree, upper select bit first, then the lower bit per half
  dmux_1to2 #(.WIDTH(WIDTH)) u_split_hl (
    .in(in), .sel(sel_p0[1]), .a(lo_p0), .b(hi_p0)
  );
  dmux_1to2 #(.WIDTH(WIDTH)) u_split_lo (
    .in(lo_p0), .sel(sel_p0[0]), .a(a_p0), .b(b_p0)
  );
  dmux_1to2 #(.WIDTH(WIDTH)) u_split_hi (
    .in(hi_p0), .sel(sel_p0[0]), .a(c_p0), .b(d_p0)
  );

  // Stage p1: output register, reset wins over enable
  always_ff @(posedge clk) begin
    if (rst) begin
      a_p1 <= '0;
      b_p1 <= '0;
      c_p1 <= '0;
      d_p1 <= '0;
    end else if (en) begin
      a_p1 <= a_p0;
      b_p1 <= b_p0;
      c_p1 <= c_p0;
      d_p1 <= d_p0;
    end
`ifndef DMUX_FOUR_WAY_HOLD_EN
    else begin
      a_p1 <= '0;
      b_p1 <= '0;
      c_p1 <= '0;
      d_p1 <= '0;
    end
`endif
  end

  assign a = a_p1;
  assign b = b_p1;
  assign c = c_p1;
  assign d = d_p1;
endmodule

// File: tb/tb_dmux_four_way.sv
// Randomized and directed bench for dmux_four_way (WIDTH=8) against a behavioural model.
module tb_dmux_four_way;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in;
  logic [1:0]   sel;
  logic         en;
  logic [W-1:0] a, b, c, d;

  dmux_four_way #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in(in), .sel(sel), .en(en),
    .a(a), .b(b), .c(c), .d(d)
  );

  always #5 clk = ~clk;

  // Behavioural model: four output slots indexed by destination number.
  logic [W-1:0] exp_out [4];
  logic         mvalid = 1'b0;

  // Hand-computed expectations requested by the stimulus for the coming edge.
  logic         pin_req_v = 1'b0;
  logic [W-1:0] pin_req [4];
  logic         pin_cur_v = 1'b0;
  logic [W-1:0] pin_cur [4];

  int vectors = 0;
  int miscompares = 0;

  always @(posedge clk) begin
    mvalid    <= 1'b1;
    pin_cur_v <= pin_req_v;
    for (int k = 0; k < 4; k++) begin
      pin_cur[k] <= pin_req[k];
      if (rst)
        exp_out[k] <= '0;
      else if (en)
        exp_out[k] <= (k == int'(sel)) ? in : '0;
`ifndef DMUX_FOUR_WAY_HOLD_EN
      else
        exp_out[k] <= '0;
`endif
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] act [4];
    act[0] = a; act[1] = b; act[2] = c; act[3] = d;
    if (mvalid) begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (act[k] !== exp_out[k]) begin
          miscompares++;
          $display("FAIL model out%0d: got %h expected %h", k, act[k], exp_out[k]);
        end
        if (pin_cur_v) begin
          vectors++;
          if (act[k] !== pin_cur[k]) begin
            miscompares++;
            $display("FAIL directed out%0d: got %h expected %h", k, act[k], pin_cur[k]);
          end
        end
      end
    end
  end

  task automatic drive(input logic r, input logic [W-1:0] i, input logic [1:0] s,
                       input logic e, input logic pv,
                       input logic [W-1:0] pa, input logic [W-1:0] pb,
                       input logic [W-1:0] pc, input logic [W-1:0] pd);
    rst = r; in = i; sel = s; en = e;
    pin_req_v = pv;
    pin_req[0] = pa; pin_req[1] = pb; pin_req[2] = pc; pin_req[3] = pd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      exp_out[k] = '0;
      pin_req[k] = '0;
      pin_cur[k] = '0;
    end

    // Reset with an otherwise active route
    drive(1, 8'h01, 2'd2, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(1, 8'h01, 2'd2, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00);

    // Select sweep
    drive(0, 8'h01, 2'd0, 1, 1, 8'h01, 8'h00, 8'h00, 8'h00);
    drive(0, 8'h01, 2'd1, 1, 1, 8'h00, 8'h01, 8'h00, 8'h00);
    drive(0, 8'h01, 2'd2, 1, 1, 8'h00, 8'h00, 8'h01, 8'h00);
    drive(0, 8'h01, 2'd3, 1, 1, 8'h00, 8'h00, 8'h00, 8'h01);

    // Zero data is indistinguishable from disabled
    for (int s = 0; s < 4; s++)
      drive(0, 8'h00, 2'(s), 1, 1, 8'h00, 8'h00, 8'h00, 8'h00);

    // Wide data
    drive(0, 8'hA5, 2'd2, 1, 1, 8'h00, 8'h00, 8'hA5, 8'h00);

    // Enable then disable
    drive(0, 8'h01, 2'd1, 1, 1, 8'h00, 8'h01, 8'h00, 8'h00);
`ifdef DMUX_FOUR_WAY_HOLD_EN
    drive(0, 8'h01, 2'd1, 0, 1, 8'h00, 8'h01, 8'h00, 8'h00);
    drive(0, 8'hFF, 2'd3, 0, 1, 8'h00, 8'h01, 8'h00, 8'h00);
`else
    drive(0, 8'h01, 2'd1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(0, 8'hFF, 2'd3, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00);
`endif

    // Mid-stream reset
    drive(0, 8'h01, 2'd3, 1, 1, 8'h00, 8'h00, 8'h00, 8'h01);
    drive(0, 8'h01, 2'd3, 1, 1, 8'h00, 8'h00, 8'h00, 8'h01);
    drive(1, 8'h01, 2'd3, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(0, 8'h01, 2'd3, 1, 1, 8'h00, 8'h00, 8'h00, 8'h01);

    // Randomized stream, checked against the model only
    for (int n = 0; n < 400; n++)
      drive(($urandom_range(0, 19) == 0), W'($urandom), 2'($urandom),
            ($urandom_range(0, 3) != 0), 0, 8'h00, 8'h00, 8'h00, 8'h00);

    drive(0, 8'h00, 2'd0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
